// File: rtl/mem_arb.sv
// mem_arb: round-robin IC/LSB arbiter serialising word requests onto a byte-wide RAM/IO port
module mem_arb #(
   parameter int ADDR_W = 32,
   parameter logic [1:0] IO_HI = 2'b11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iIC_En,
   input  logic [ADDR_W-1:0] iIC_Addr,
   output logic              oIC_En,
   output logic [31:0]       oIC_Dat,
   input  logic              iLS_En,
   input  logic              iLS_Wr,
   input  logic [1:0]        iLS_Len,
   input  logic [ADDR_W-1:0] iLS_Addr,
   input  logic [31:0]       iLS_Dat,
   output logic              oLS_En,
   output logic [31:0]       oLS_Dat,
   input  logic              iROB_Mp,
   input  logic [7:0]        iRAM_Din,
   output logic [7:0]        oRAM_Dout,
   output logic [ADDR_W-1:0] oRAM_A,
   output logic              oRAM_Wr,
   input  logic              iIO_Full
);
   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] addr, addr_nx, cur_a;
   logic [31:0] data, data_nx;
   logic [2:0] n, n_nx, k, k_nx, ls_n;
   logic [1:0] lane;
   logic own_ls, own_nx, wr, wr_nx, last, last_nx;
   logic grant_ls, grant_ic, stall, rd_act, pulse;
   assign cur_a = addr + ADDR_W'(k);
   assign lane = 2'(k - 3'd1);
   assign ls_n = iLS_Len == 2'd0 ? 3'd1 : iLS_Len == 2'd1 ? 3'd2 : 3'd4;
   assign grant_ls = iLS_En && (!iIC_En || !last);
   assign grant_ic = iIC_En && !grant_ls;
   assign stall = wr && addr[17:16] == IO_HI && iIO_Full;
   // In RD, k counts issue cycles; the byte for address k-1 arrives while k is driven
   always_comb begin
      state_nx = state;
      addr_nx = addr;
      data_nx = data;
      n_nx = n;
      k_nx = k;
      own_nx = own_ls;
      wr_nx = wr;
      last_nx = last;
      case (state)
         IDLE: if (!iROB_Mp && (grant_ls || grant_ic)) begin
            addr_nx = grant_ls ? iLS_Addr : iIC_Addr;
            n_nx = grant_ls ? ls_n : 3'd4;
            wr_nx = grant_ls && iLS_Wr;
            data_nx = (grant_ls && iLS_Wr) ? iLS_Dat : 32'd0;
            own_nx = grant_ls;
            last_nx = grant_ls;
            k_nx = 3'd0;
            state_nx = (grant_ls && iLS_Wr) ? WR : RD;
         end
         RD: if (iROB_Mp) begin
            state_nx = IDLE;
            k_nx = 3'd0;
         end else begin
            if (k != 3'd0) data_nx[{lane, 3'b000} +: 8] = iRAM_Din;
            if (k == n) state_nx = RESP;
            else k_nx = k + 3'd1;
         end
         WR: if (!stall) begin
            if (k == n - 3'd1) state_nx = RESP;
            else k_nx = k + 3'd1;
         end
         default: begin
            state_nx = IDLE;
            k_nx = 3'd0;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         addr <= '0;
         data <= '0;
         n <= '0;
         k <= '0;
         own_ls <= 1'b0;
         wr <= 1'b0;
         last <= 1'b0;
      end else begin
         state <= state_nx;
         addr <= addr_nx;
         data <= data_nx;
         n <= n_nx;
         k <= k_nx;
         own_ls <= own_nx;
         wr <= wr_nx;
         last <= last_nx;
      end
   end
   assign rd_act = state == RD && k != n;
   assign oRAM_A = (rd_act || state == WR) ? cur_a : '0;
   assign oRAM_Wr = state == WR && !stall;
   assign oRAM_Dout = state == WR ? data[{k[1:0], 3'b000} +: 8] : 8'd0;
   // A flush seen during a read's response cycle cancels its completion
   assign pulse = state == RESP && !(iROB_Mp && !wr);
   assign oIC_En = pulse && !own_ls;
   assign oLS_En = pulse && own_ls;
   assign oIC_Dat = oIC_En ? data : 32'd0;
   assign oLS_Dat = (oLS_En && !wr) ? data : 32'd0;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench with a transaction-level model feeding a per-cycle compare process
module tb_mem_arb;
   logic clk = 0, rst = 0;
   logic iIC_En = 0, iLS_En = 0, iLS_Wr = 0, iROB_Mp = 0, iIO_Full = 0;
   logic [31:0] iIC_Addr = 0, iLS_Addr = 0, iLS_Dat = 0;
   logic [1:0] iLS_Len = 0;
   logic [7:0] iRAM_Din;
   logic oIC_En, oLS_En, oRAM_Wr;
   logic [31:0] oIC_Dat, oLS_Dat, oRAM_A;
   logic [7:0] oRAM_Dout;

   mem_arb dut (.clk(clk), .rst(rst), .iIC_En(iIC_En), .iIC_Addr(iIC_Addr), .oIC_En(oIC_En),
      .oIC_Dat(oIC_Dat), .iLS_En(iLS_En), .iLS_Wr(iLS_Wr), .iLS_Len(iLS_Len), .iLS_Addr(iLS_Addr),
      .iLS_Dat(iLS_Dat), .oLS_En(oLS_En), .oLS_Dat(oLS_Dat), .iROB_Mp(iROB_Mp), .iRAM_Din(iRAM_Din),
      .oRAM_Dout(oRAM_Dout), .oRAM_A(oRAM_A), .oRAM_Wr(oRAM_Wr), .iIO_Full(iIO_Full));

   always #5 clk = ~clk;

   typedef struct packed {
      logic chk_a; logic [31:0] a; logic wr; logic [7:0] dout;
      logic ic_en; logic [31:0] ic_dat; logic ls_en; logic [31:0] ls_dat;
   } exp_t;

   exp_t q[$];
   exp_t e;
   logic [7:0] mem [0:65535];
   int n_checks = 0, n_fail = 0, cyc = 0, e1;
   logic chk_on = 0;
   logic [31:0] hist_a [0:2047], hist_icdat [0:2047], hist_lsdat [0:2047];
   logic [7:0] hist_dout [0:2047];
   logic hist_wr [0:2047], hist_ic [0:2047], hist_ls [0:2047];

   function automatic exp_t mk(logic c, logic [31:0] a, logic w, logic [7:0] d,
                               logic ie, logic [31:0] id, logic le, logic [31:0] ld);
      mk = {c, a, w, d, ie, id, le, ld};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // byte RAM: read data shows up one cycle after its address
   always @(posedge clk) begin
      if (oRAM_Wr) mem[oRAM_A[15:0]] <= oRAM_Dout;
      iRAM_Din <= mem[oRAM_A[15:0]];
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (chk_on) begin
      hist_a[cyc] = oRAM_A; hist_dout[cyc] = oRAM_Dout; hist_wr[cyc] = oRAM_Wr;
      hist_ic[cyc] = oIC_En; hist_icdat[cyc] = oIC_Dat;
      hist_ls[cyc] = oLS_En; hist_lsdat[cyc] = oLS_Dat;
      if (q.size() > 0) e = q.pop_front();
      else e = mk(1, 0, 0, 0, 0, 0, 0, 0);
      if (e.chk_a) begin
         chk("ram_a", oRAM_A, e.a);
         chk("ram_dout", {24'd0, oRAM_Dout}, {24'd0, e.dout});
      end
      chk("ram_wr", {31'd0, oRAM_Wr}, {31'd0, e.wr});
      chk("ic_en", {31'd0, oIC_En}, {31'd0, e.ic_en});
      chk("ic_dat", oIC_Dat, e.ic_dat);
      chk("ls_en", {31'd0, oLS_En}, {31'd0, e.ls_en});
      chk("ls_dat", oLS_Dat, e.ls_dat);
   end

   // expected per-cycle outputs for one granted transaction, cycles 1..L
   task automatic push_tx(bit ls, bit w, logic [31:0] a, int n, logic [31:0] d, int s);
      logic [31:0] r = 0, ra;
      if (w) begin
         for (int i = 0; i < s; i++) q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
         for (int i = 0; i < n; i++) q.push_back(mk(1, 32'(a + i), 1, d[8*i +: 8], 0, 0, 0, 0));
         q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0));
      end else begin
         for (int i = 0; i < n; i++) begin
            ra = 32'(a + i);
            q.push_back(mk(1, ra, 0, 0, 0, 0, 0, 0));
            r = r | ({24'd0, mem[ra[15:0]]} << (8 * i));
         end
         q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
         q.push_back(mk(1, 0, 0, 0, !ls, ls ? 0 : r, ls, ls ? r : 0));
      end
      q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic set_ls(bit w, logic [1:0] len, logic [31:0] a, logic [31:0] d);
      iLS_En = 1; iLS_Wr = w; iLS_Len = len; iLS_Addr = a; iLS_Dat = d;
   endtask

   task automatic do_tx(bit ls, bit w, logic [31:0] a, int n, logic [31:0] d, int s, int mp_c,
                        output int first);
      int len_c = w ? s + n + 2 : n + 3;
      iIO_Full = s > 0;
      @(posedge clk);
      push_tx(ls, w, a, n, d, s);
      #1;
      first = cyc;
      for (int c = 1; c < len_c; c++) begin
         if (c == s + 1) iIO_Full = 0;
         iROB_Mp = c == mp_c;
         @(posedge clk);
         #1;
      end
      iROB_Mp = 0;
      iIO_Full = 0;
      if (ls) iLS_En = 0;
      else iIC_En = 0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      {mem[16'h1000], mem[16'h1001], mem[16'h1002], mem[16'h1003]} = {8'h13, 8'h05, 8'h00, 8'h00};
      {mem[0], mem[1], mem[2], mem[3]} = {8'h01, 8'h02, 8'h03, 8'h04};
      mem[16'h2000] = 8'h5A; mem[16'h2001] = 8'h6B; mem[16'h2002] = 8'h7C; mem[16'h2003] = 8'h8D;
      mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB;
      @(posedge clk);
      chk_on = 1;
      #1 chk("rst_ram_a", oRAM_A, 0);
      @(posedge clk);
      #1 rst = 1;
      // reset then IC fetch
      iIC_En = 1; iIC_Addr = 32'h1000;
      do_tx(0, 0, 32'h1000, 4, 0, 0, 0, e1);
      chk("lit_fetch_a0", hist_a[e1], 32'h1000);
      chk("lit_fetch_a3", hist_a[e1 + 3], 32'h1003);
      chk("lit_fetch_early", {31'd0, hist_ic[e1 + 4]}, 0);
      chk("lit_fetch_en", {31'd0, hist_ic[e1 + 5]}, 1);
      chk("lit_fetch_dat", hist_icdat[e1 + 5], 32'h00000513);
      // simultaneous: LSB first, then IC
      iIC_En = 1; iIC_Addr = 0; set_ls(0, 0, 32'h2000, 0);
      do_tx(1, 0, 32'h2000, 1, 0, 0, 0, e1);
      chk("lit_ls1_en", {31'd0, hist_ls[e1 + 2]}, 1);
      chk("lit_ls1_dat", hist_lsdat[e1 + 2], 32'h0000005A);
      do_tx(0, 0, 0, 4, 0, 0, 0, e1);
      chk("lit_ic0_dat", hist_icdat[e1 + 5], 32'h04030201);
      // store 2 bytes
      set_ls(1, 1, 32'h10, 32'hA1B2C3D4);
      do_tx(1, 1, 32'h10, 2, 32'hA1B2C3D4, 0, 0, e1);
      chk("lit_st_a", hist_a[e1], 32'h10);
      chk("lit_st_d0", {24'd0, hist_dout[e1]}, 32'hD4);
      chk("lit_st_d1", {24'd0, hist_dout[e1 + 1]}, 32'hC3);
      chk("lit_st_en", {31'd0, hist_ls[e1 + 2]}, 1);
      // both again, IC served last time was not the winner: IC now
      iIC_En = 1; iIC_Addr = 32'h1000; set_ls(0, 2, 32'h2000, 0);
      do_tx(0, 0, 32'h1000, 4, 0, 0, 0, e1);
      chk("lit_rr_ic", {31'd0, hist_ic[e1 + 5]}, 1);
      do_tx(1, 0, 32'h2000, 4, 0, 0, 0, e1);
      chk("lit_rr_ls", hist_lsdat[e1 + 5], 32'h8D7C6B5A);
      // IO stall
      set_ls(1, 0, 32'h30100, 32'h000000EE);
      do_tx(1, 1, 32'h30100, 1, 32'h000000EE, 3, 0, e1);
      chk("lit_io_stall", {29'd0, hist_wr[e1], hist_wr[e1 + 1], hist_wr[e1 + 2]}, 0);
      chk("lit_io_wr", {31'd0, hist_wr[e1 + 3]}, 1);
      chk("lit_io_en", {31'd0, hist_ls[e1 + 4]}, 1);
      // mispredicted fetch, then LSB load
      iIC_En = 1; iIC_Addr = 32'h1000;
      @(posedge clk);
      q.push_back(mk(1, 32'h1000, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(1, 32'h1001, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      #1;
      @(posedge clk);
      #1 iROB_Mp = 1;
      @(posedge clk);
      #1 iROB_Mp = 0; iIC_En = 0; set_ls(0, 1, 32'h10, 0);
      do_tx(1, 0, 32'h10, 2, 0, 0, 0, e1);
      chk("lit_mp_ld", hist_lsdat[e1 + 3], 32'h0000C3D4);
      // flush during a store must not stop it
      set_ls(1, 2, 32'h40, 32'h11223344);
      do_tx(1, 1, 32'h40, 4, 32'h11223344, 0, 2, e1);
      chk("lit_mpst_en", {31'd0, hist_ls[e1 + 4]}, 1);
      set_ls(0, 3, 32'h40, 0);
      do_tx(1, 0, 32'h40, 4, 0, 0, 0, e1);
      chk("lit_len3_dat", hist_lsdat[e1 + 5], 32'h11223344);
      // address wrap
      set_ls(0, 2, 32'hFFFFFFFE, 0);
      do_tx(1, 0, 32'hFFFFFFFE, 4, 0, 0, 0, e1);
      chk("lit_wrap_a1", hist_a[e1 + 1], 32'hFFFFFFFF);
      chk("lit_wrap_a3", hist_a[e1 + 3], 32'h1);
      chk("lit_wrap_dat", hist_lsdat[e1 + 5], 32'h0201BBAA);
      repeat (3) @(posedge clk);
      #1 chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arb.md
# mem_arb

Memory arbiter/sequencer between the instruction-cache fetch path and the load/store buffer (LSB), sharing the single byte-wide RAM/IO port. It accepts one word-fetch request from the IC and one load/store request from the LSB, grants them round-robin, and serialises each request into 1/2/4 byte-wide RAM accesses. It returns the assembled little-endian data with a one-cycle completion pulse. On misprediction it aborts speculative reads.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `IO_HI`, 2'b11: value of addr[17:16] that selects IO space.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-low reset; `rst`=0 on an edge resets the block.
- `iIC_En`  in  1  IC fetch request; held until `oIC_En`.
- `iIC_Addr`  in  ADDR_W  fetch address; always a 4-byte read.
- `oIC_En`  out  1  one-cycle fetch-done pulse.
- `oIC_Dat`  out  32  fetched word; valid while `oIC_En`=1.
- `iLS_En`  in  1  LSB request; held until `oLS_En`.
- `iLS_Wr`  in  1  1 = store, 0 = load.
- `iLS_Len`  in  2  0: 1 B, 1: 2 B, 2: 4 B; 3 is treated as 4 B.
- `iLS_Addr`  in  ADDR_W  byte address.
- `iLS_Dat`  in  32  store data, little-endian.
- `oLS_En`  out  1  one-cycle done pulse for loads and stores.
- `oLS_Dat`  out  32  load data, zero-extended raw bytes; 0 for stores.
- `iROB_Mp`  in  1  misprediction flush.
- `iRAM_Din`  in  8  RAM read byte.
- `oRAM_Dout`  out  8  RAM write byte.
- `oRAM_A`  out  ADDR_W  RAM byte address.
- `oRAM_Wr`  out  1  1 = write this cycle.
- `iIO_Full`  in  1  IO buffer full; IO writes must wait.

## Operation
- States:
  - IDLE: samples requests.
  - RD: read in progress.
  - WR: write in progress.
  - RESP: one cycle, raises the done pulse.
- Arbitration in IDLE:
  - Only one requester active: grant it.
  - Both active: grant the one not granted last (`last` bit). Initial `last` = IC, so the LSB wins first.
  - On grant, latch address, length n (4 for IC), store data and owner; set `last` = owner; clear byte counter k.
- RD:
  - Drive `oRAM_A` = A+k for k = 0..n-1, `oRAM_Wr`=0.
  - The byte for the address driven in cycle c appears on `iRAM_Din` in cycle c+1 and is captured into byte lane k.
  - After the last byte is captured, go to RESP.
- WR:
  - Drive `oRAM_A` = A+k, `oRAM_Dout` = data[8k+7:8k], `oRAM_Wr`=1.
  - If addr[17:16]==IO_HI and `iIO_Full`=1: drive `oRAM_Wr`=0 and hold k (stall).
  - After byte n-1 is written, go to RESP.
- RESP: pulse the owner's `oX_En` for one cycle with the data; next state IDLE. Requests are ignored during RESP.
- Address arithmetic: A+k wraps modulo 2^ADDR_W. Unused upper data lanes are 0.
- Misprediction, `iROB_Mp`=1 on an edge:
  - In RD, or in RESP of a read: return to IDLE and suppress the pulse. `oRAM_Wr`=0 and `oRAM_A`=0 next cycle. `last` is unchanged.
  - In WR, or in RESP of a store: ignored; stores are committed and always complete.
  - In IDLE: no grant on that edge.
- Reset: state IDLE, k=0, `last`=IC, all outputs 0. Reset mid-transaction abandons it, including writes.

## Timing
- Edge E0 grants the request; cycle i is the i-th cycle after E0.
- Read of n bytes:
  - `oRAM_A` = A+k in cycle 1+k.
  - Byte k is captured at the end of cycle 2+k.
  - RESP in cycle n+2, pulse `oX_En`=1.
  - IDLE in cycle n+3; the next grant is at the end of cycle n+3.
  - IC fetch: pulse in cycle 6, next grant 7 cycles after E0.
- Write of n bytes (no stall): Wr=1 in cycles 1..n, pulse in cycle n+1, IDLE in cycle n+2. Each stall cycle adds 1.
- Between accesses (IDLE, RESP): `oRAM_Wr`=0, `oRAM_A`=0, `oRAM_Dout`=0.
- `oIC_En` and `oLS_En` are never high together and never high for more than one cycle.
- A requester drops or changes `En` no earlier than the cycle after its pulse.

## Test plan
- Reset and IC fetch:
  - Stimulus: `rst`=0 for 2 edges; then IC fetch at 0x1000 with RAM bytes 13 05 00 00.
  - Required: all outputs 0 during reset; `oRAM_A` 0x1000..0x1003 in cycles 1–4; `oIC_En`=1, `oIC_Dat`=0x00000513 in cycle 6 only.
- Simultaneous requests:
  - Stimulus: IC at 0x0 and LSB 1-byte load at 0x2000 both asserted after reset.
  - Required: LSB granted first, `oLS_En` in cycle 3 with `oLS_Dat`=0x000000xx; IC granted next.
  - Second round: both asserted again → IC wins (round-robin).
- Store:
  - Stimulus: LSB store, Len=1, addr 0x10, data 0xA1B2C3D4.
  - Required: cycle 1 A=0x10, Dout=0xD4, Wr=1; cycle 2 A=0x11, Dout=0xC3, Wr=1; `oLS_En` in cycle 3.
- IO stall:
  - Stimulus: 1-byte store to 0x30000 with `iIO_Full`=1 for cycles 1–3.
  - Required: Wr=0 in cycles 1–3, write in cycle 4, pulse in cycle 5.
- Misprediction:
  - Stimulus: `iROB_Mp` at end of cycle 2 of an IC fetch.
  - Required: no `oIC_En`; Wr=0, A=0 from cycle 3; LSB request granted next.
  - Stimulus: `iROB_Mp` during a 4-byte store.
  - Required: all 4 bytes written and `oLS_En` pulsed.
- Wrap-around: 4-byte load at 0xFFFFFFFE → addresses FFFFFFFE, FFFFFFFF, 0, 1.
